usd_spi_reg_master: RTL and testbench

- SPI master that drives the register-write link into the Doppler board's SPI-slave communication layer. It serialises one 8-bit register address and one 16-bit value per transaction onto SRCLK/nSRSYNC/SRDATA.
- It captures the slave's 24-bit MISO reply in the same transaction.
- It is used in bench harnesses and in the host-side controller FPGA to program burst, ADC and power-down registers of the USD core.

---
 rtl/usd_spi_pkg.sv | 25 ++
 rtl/usd_spi_clkgen.sv | 70 +++++++
 rtl/usd_spi_reg_master.sv | 192 +++++++++++++++++++
 tb/tb_usd_spi_reg_master.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usd_spi_pkg.sv
// Shared definitions for the USD register-write SPI link (master and slave side).
// Holds the frame geometry and the transaction state encoding.
// No ports; imported by usd_spi_clkgen and usd_spi_reg_master.
package usd_spi_pkg;

  // Frame geometry: one register address followed by one register value.
  localparam int FRAME_W   = 24;
  localparam int REG_W     = 8;
  localparam int VAL_W     = 16;

  // Bit index counter covers 0..FRAME_W-1.
  localparam int BIT_CNT_W = 5;

  // Phase/delay counters cover the 1..255 parameter range.
  localparam int CNT_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_e;

endpackage

// File: rtl/usd_spi_clkgen.sv
// SRCLK generator: DIV-cycle high and low phases, enabled only while shifting.
// Latency: SRCLK is registered; strobes are combinational and flag the edge that
//          changes SRCLK. No backpressure; en_i/start_i/stop_i steer it directly.
// Ports:
//   clk_i, rst_ni    system clock and synchronous active-low reset
//   en_i             high while the master is in its shift state
//   start_i          one-cycle request for the very first rising edge
//   stop_i           suppresses the rising edge at the end of a low phase
//   sclk_o           SPI clock, idles low
//   rise_strobe_o    this edge takes SRCLK 0->1
//   fall_strobe_o    this edge takes SRCLK 1->0
//   low_end_o        this edge ends a low phase (whether or not a rise follows)
module usd_spi_clkgen
  import usd_spi_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic start_i,
  input  logic stop_i,
  output logic sclk_o,
  output logic rise_strobe_o,
  output logic fall_strobe_o,
  output logic low_end_o
);

  localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic             phase_end;

  assign phase_end     = (cnt_q == PHASE_LAST);
  assign low_end_o     = en_i & ~sclk_q & phase_end;
  // The first rise comes from the caller because the low phase before it is
  // the chip-select setup time, not a clock phase.
  assign rise_strobe_o = start_i | (low_end_o & ~stop_i);
  assign fall_strobe_o = en_i & sclk_q & phase_end;
  assign sclk_o        = sclk_q;

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (rise_strobe_o) begin
      sclk_d = 1'b1;
      cnt_d  = '0;
    end else if (fall_strobe_o) begin
      sclk_d = 1'b0;
      cnt_d  = '0;
    end else if (en_i) begin
      cnt_d  = cnt_q + 1'b1;
    end else begin
      sclk_d = 1'b0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/usd_spi_reg_master.sv
// SPI mode-0 master writing one 8-bit address + 16-bit value per frame and
// capturing the 24-bit MISO reply of the same frame.
// Latency: CS_SETUP + 48*DIV + CS_HOLD + GAP cycles from acceptance back to idle;
//          rsp_valid fires on the first GAP cycle. Backpressure: cmd_ready is
//          high only in IDLE; nothing throttles rsp_valid.
// Ports:
//   CLK_64MHz, nRESET            system clock, synchronous active-low reset
//   cmd_valid/cmd_ready          command handshake; cmd_reg then cmd_value, MSB first
//   rsp_valid/rsp_data           one-cycle reply pulse, first-sampled bit at [23]
//   busy                         high from acceptance until the end of the gap
//   SRCLK/nSRSYNC/SRDATA/SRMISO  SPI pins (SRMISO assumed already synchronous)
module usd_spi_reg_master
  import usd_spi_pkg::*;
#(
  parameter int unsigned DIV      = 4,
  parameter int unsigned CS_SETUP = 4,
  parameter int unsigned CS_HOLD  = 4,
  parameter int unsigned GAP      = 8
) (
  input  logic               CLK_64MHz,
  input  logic               nRESET,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [REG_W-1:0]   cmd_reg,
  input  logic [VAL_W-1:0]   cmd_value,
  output logic               rsp_valid,
  output logic [FRAME_W-1:0] rsp_data,
  output logic               busy,
  output logic               SRCLK,
  output logic               nSRSYNC,
  output logic               SRDATA,
  input  logic               SRMISO
);

  localparam logic [CNT_W-1:0]     SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0]     HOLD_LAST  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0]     GAP_LAST   = CNT_W'(GAP - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST   = BIT_CNT_W'(FRAME_W - 1);

  spi_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_CNT_W-1:0] bit_q, bit_d;
  logic [FRAME_W-1:0]   tx_q, tx_d;
  logic [FRAME_W-1:0]   rx_q, rx_d;
  logic                 srdata_q, srdata_d;
  logic                 nsync_q, nsync_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [FRAME_W-1:0]   rsp_data_q, rsp_data_d;

  logic                 in_shift;
  logic                 setup_end;
  logic                 last_bit;
  logic                 rise_strobe;
  logic                 fall_strobe;
  logic                 low_end;

  assign in_shift  = (state_q == ST_SHIFT);
  assign setup_end = (state_q == ST_SETUP) && (cnt_q == SETUP_LAST);
  // bit_q counts rises after the first one, so it names the bit currently on
  // the wire; it reaches BIT_LAST during the final bit period and stays there
  // through the final low phase.
  assign last_bit  = (bit_q == BIT_LAST);

  usd_spi_clkgen #(
    .DIV (DIV)
  ) u_clkgen (
    .clk_i         (CLK_64MHz),
    .rst_ni        (nRESET),
    .en_i          (in_shift),
    .start_i       (setup_end),
    .stop_i        (last_bit),
    .sclk_o        (SRCLK),
    .rise_strobe_o (rise_strobe),
    .fall_strobe_o (fall_strobe),
    .low_end_o     (low_end)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    srdata_d    = srdata_q;
    nsync_d     = nsync_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;

    // Includes the first rise, which is issued while still in SETUP.
    if (rise_strobe) begin
      rx_d = {rx_q[FRAME_W-2:0], SRMISO};
    end

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          tx_d     = {cmd_reg, cmd_value};
          srdata_d = cmd_reg[REG_W-1];
          nsync_d  = 1'b0;
          cnt_d    = '0;
          bit_d    = '0;
          state_d  = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_SHIFT: begin
        if (rise_strobe) begin
          bit_d = bit_q + 1'b1;
        end
        // The final falling edge leaves value[0] on SRDATA through HOLD.
        if (fall_strobe && !last_bit) begin
          tx_d     = {tx_q[FRAME_W-2:0], 1'b0};
          srdata_d = tx_q[FRAME_W-2];
        end
        if (low_end && last_bit) begin
          cnt_d   = '0;
          state_d = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d       = '0;
          nsync_d     = 1'b1;
          srdata_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = rx_q;
          state_d     = ST_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        nsync_d  = 1'b1;
        srdata_d = 1'b0;
        cnt_d    = '0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_64MHz) begin
    if (!nRESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      srdata_q    <= 1'b0;
      nsync_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      srdata_q    <= srdata_d;
      nsync_q     <= nsync_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign nSRSYNC   = nsync_q;
  assign SRDATA    = srdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_usd_spi_reg_master.sv
// Bench for usd_spi_reg_master: one instance at default timing, one at minimum
// timing (all parameters 1), each driven by a mode-0 slave model that either
// echoes MOSI or replays a chosen 24-bit word.
module tb_usd_spi_reg_master;

  localparam int P_DIV [2] = '{4, 1};
  localparam int P_SET [2] = '{4, 1};
  localparam int P_HLD [2] = '{4, 1};
  localparam int P_GAP [2] = '{8, 1};

  logic        clk;
  logic        nreset    [2];
  logic        cmd_valid [2];
  logic        cmd_ready [2];
  logic [7:0]  cmd_reg   [2];
  logic [15:0] cmd_value [2];
  logic        rsp_valid [2];
  logic [23:0] rsp_data  [2];
  logic        busy      [2];
  logic        srclk     [2];
  logic        nsync     [2];
  logic        srdata    [2];
  logic        srmiso    [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Slave model and frame monitor state.
  int          mode [2];
  logic [23:0] sword [2];
  logic [23:0] msh [2];
  int          rises [2], falls [2], nfall [2], rsp_cnt [2];
  int          t_csf [2], t_csr [2], t_r1 [2], t_r [2], t_fl [2], t_rsp [2], cs_hi [2];
  logic [23:0] mosi [2], mosi_done [2], rsp_last [2];
  logic        phase_bad [2], edge_bad [2], prev_ns [2], prev_sc [2];

  assign srmiso[0] = (mode[0] != 0) ? msh[0][23] : srdata[0];
  assign srmiso[1] = (mode[1] != 0) ? msh[1][23] : srdata[1];

  usd_spi_reg_master #(.DIV(4), .CS_SETUP(4), .CS_HOLD(4), .GAP(8)) dut0 (
    .CLK_64MHz (clk),          .nRESET    (nreset[0]),
    .cmd_valid (cmd_valid[0]), .cmd_ready (cmd_ready[0]),
    .cmd_reg   (cmd_reg[0]),   .cmd_value (cmd_value[0]),
    .rsp_valid (rsp_valid[0]), .rsp_data  (rsp_data[0]),
    .busy      (busy[0]),      .SRCLK     (srclk[0]),
    .nSRSYNC   (nsync[0]),     .SRDATA    (srdata[0]),
    .SRMISO    (srmiso[0])
  );

  usd_spi_reg_master #(.DIV(1), .CS_SETUP(1), .CS_HOLD(1), .GAP(1)) dut1 (
    .CLK_64MHz (clk),          .nRESET    (nreset[1]),
    .cmd_valid (cmd_valid[1]), .cmd_ready (cmd_ready[1]),
    .cmd_reg   (cmd_reg[1]),   .cmd_value (cmd_value[1]),
    .rsp_valid (rsp_valid[1]), .rsp_data  (rsp_data[1]),
    .busy      (busy[1]),      .SRCLK     (srclk[1]),
    .nSRSYNC   (nsync[1]),     .SRDATA    (srdata[1]),
    .SRMISO    (srmiso[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Frame monitor, sampling at the falling clock edge.
  initial begin
    for (int i = 0; i < 2; i++) begin
      msh[i] = '0; rises[i] = 0; falls[i] = 0; nfall[i] = 0; rsp_cnt[i] = 0;
      t_csf[i] = 0; t_csr[i] = 0; t_r1[i] = 0; t_r[i] = 0; t_fl[i] = 0;
      t_rsp[i] = 0; cs_hi[i] = 0; mosi[i] = '0; mosi_done[i] = '0;
      rsp_last[i] = '0; phase_bad[i] = 1'b0; edge_bad[i] = 1'b0;
      prev_ns[i] = 1'b1; prev_sc[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (prev_ns[i] && !nsync[i]) begin
          nfall[i]++;
          rises[i] = 0; falls[i] = 0; mosi[i] = '0;
          phase_bad[i] = 1'b0; edge_bad[i] = 1'b0;
          t_csf[i] = cyc; cs_hi[i] = cyc - t_csr[i];
          msh[i] = sword[i];
        end
        if (!prev_ns[i] && nsync[i]) begin
          t_csr[i] = cyc;
          mosi_done[i] = mosi[i];
        end
        if ((srclk[i] != prev_sc[i]) && prev_ns[i] && nsync[i]) edge_bad[i] = 1'b1;
        if (srclk[i] && !prev_sc[i]) begin
          rises[i]++;
          if (rises[i] == 1) t_r1[i] = cyc;
          else if (cyc - t_fl[i] != P_DIV[i]) phase_bad[i] = 1'b1;
          t_r[i] = cyc;
          mosi[i] = {mosi[i][22:0], srdata[i]};
        end
        if (!srclk[i] && prev_sc[i]) begin
          falls[i]++;
          if (cyc - t_r[i] != P_DIV[i]) phase_bad[i] = 1'b1;
          t_fl[i] = cyc;
          msh[i] = {msh[i][22:0], 1'b0};
        end
        if (rsp_valid[i]) begin
          rsp_cnt[i]++;
          rsp_last[i] = rsp_data[i];
          t_rsp[i] = cyc;
        end
        prev_ns[i] = nsync[i];
        prev_sc[i] = srclk[i];
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // One full transaction on instance i with slave mode m (0 echo, 1 replay w).
  task automatic run_txn(input int i, input logic [7:0] r, input logic [15:0] v,
                         input int m, input logic [23:0] w, input string tag);
    int a;
    int c0;
    logic [23:0] exp_rsp;
    mode[i] = m;
    sword[i] = w;
    for (int k = 0; k < 500 && !cmd_ready[i]; k++) step();
    chk({tag, " idle_before"}, 32'(cmd_ready[i]), 32'd1);
    c0 = rsp_cnt[i];
    cmd_valid[i] = 1'b1; cmd_reg[i] = r; cmd_value[i] = v;
    step();
    a = cyc;
    cmd_valid[i] = 1'b0;
    cmd_reg[i] = 8'($urandom);
    cmd_value[i] = 16'($urandom);
    chk({tag, " ready_low"}, 32'(cmd_ready[i]), 32'd0);
    chk({tag, " busy_high"}, 32'(busy[i]), 32'd1);
    chk({tag, " cs_low"}, 32'(nsync[i]), 32'd0);
    chk({tag, " first_bit"}, 32'(srdata[i]), 32'(r[7]));
    for (int k = 0; k < 3000 && !cmd_ready[i]; k++) step();
    chk({tag, " done"}, 32'(cmd_ready[i]), 32'd1);
    chk({tag, " frame_len"}, 32'(cyc - a),
        32'(P_SET[i] + 48 * P_DIV[i] + P_HLD[i] + P_GAP[i]));
    chk({tag, " rsp_count"}, 32'(rsp_cnt[i] - c0), 32'd1);
    chk({tag, " rsp_time"}, 32'(t_rsp[i] - a), 32'(P_SET[i] + 48 * P_DIV[i] + P_HLD[i]));
    exp_rsp = (m != 0) ? w : {r, v};
    chk({tag, " rsp_data"}, 32'(rsp_last[i]), 32'(exp_rsp));
    chk({tag, " rsp_hold"}, 32'(rsp_data[i]), 32'(exp_rsp));
    chk({tag, " mosi"}, 32'(mosi_done[i]), 32'({r, v}));
    chk({tag, " rises"}, 32'(rises[i]), 32'd24);
    chk({tag, " falls"}, 32'(falls[i]), 32'd24);
    chk({tag, " setup"}, 32'(t_r1[i] - t_csf[i]), 32'(P_SET[i]));
    chk({tag, " hold"}, 32'(t_csr[i] - t_fl[i]), 32'(P_DIV[i] + P_HLD[i]));
    chk({tag, " phases"}, 32'(phase_bad[i]), 32'd0);
    chk({tag, " edge_idle"}, 32'(edge_bad[i]), 32'd0);
  endtask

  initial begin
    int a1;
    int a2;
    int c0;
    int f0;
    for (int i = 0; i < 2; i++) begin
      nreset[i] = 1'b0; cmd_valid[i] = 1'b0; cmd_reg[i] = '0; cmd_value[i] = '0;
      mode[i] = 0; sword[i] = '0;
    end
    repeat (3) step();
    for (int i = 0; i < 2; i++) begin
      chk("rst cmd_ready", 32'(cmd_ready[i]), 32'd1);
      chk("rst busy", 32'(busy[i]), 32'd0);
      chk("rst nsrsync", 32'(nsync[i]), 32'd1);
      chk("rst srclk", 32'(srclk[i]), 32'd0);
      chk("rst srdata", 32'(srdata[i]), 32'd0);
      chk("rst rsp_valid", 32'(rsp_valid[i]), 32'd0);
      chk("rst rsp_data", 32'(rsp_data[i]), 32'd0);
    end
    nreset[0] = 1'b1;
    nreset[1] = 1'b1;
    step();

    run_txn(0, 8'h12, 16'hA55A, 0, 24'h0, "d0_echo");
    run_txn(0, 8'h5C, 16'h3C96, 1, 24'hFFFFFF, "d0_miso1");
    run_txn(0, 8'hC3, 16'h0F0F, 1, 24'h000000, "d0_miso0");

    // Back-to-back with cmd_valid held high across both frames.
    mode[0] = 0;
    for (int k = 0; k < 500 && !cmd_ready[0]; k++) step();
    c0 = rsp_cnt[0];
    cmd_valid[0] = 1'b1; cmd_reg[0] = 8'h01; cmd_value[0] = 16'h0001;
    step();
    a1 = cyc;
    f0 = nfall[0];
    cmd_reg[0] = 8'hFF; cmd_value[0] = 16'hFFFF;
    for (int k = 0; k < 1000 && nfall[0] == f0; k++) step();
    a2 = cyc;
    cmd_valid[0] = 1'b0;
    chk("b2b second_frame", 32'(nfall[0] - f0), 32'd1);
    chk("b2b accept_spacing", 32'(a2 - a1), 32'(4 + 48 * 4 + 4 + 8 + 1));
    chk("b2b cs_high", 32'(cs_hi[0]), 32'd9);
    chk("b2b mosi1", 32'(mosi_done[0]), 32'h010001);
    chk("b2b rsp1", 32'(rsp_last[0]), 32'h010001);
    for (int k = 0; k < 1000 && !cmd_ready[0]; k++) step();
    chk("b2b rsp_count", 32'(rsp_cnt[0] - c0), 32'd2);
    chk("b2b mosi2", 32'(mosi_done[0]), 32'hFFFFFF);
    chk("b2b rsp2", 32'(rsp_last[0]), 32'hFFFFFF);

    // Reset at the 10th SRCLK rise, then a clean transaction.
    mode[0] = 1;
    sword[0] = 24'($urandom);
    for (int k = 0; k < 500 && !cmd_ready[0]; k++) step();
    c0 = rsp_cnt[0];
    cmd_valid[0] = 1'b1; cmd_reg[0] = 8'($urandom); cmd_value[0] = 16'($urandom);
    step();
    cmd_valid[0] = 1'b0;
    for (int k = 0; k < 1000 && rises[0] < 10; k++) step();
    chk("mid_rst reached_rise10", 32'(rises[0]), 32'd10);
    nreset[0] = 1'b0;
    step();
    chk("mid_rst nsrsync", 32'(nsync[0]), 32'd1);
    chk("mid_rst srclk", 32'(srclk[0]), 32'd0);
    chk("mid_rst cmd_ready", 32'(cmd_ready[0]), 32'd1);
    chk("mid_rst rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("mid_rst busy", 32'(busy[0]), 32'd0);
    repeat (2) step();
    nreset[0] = 1'b1;
    repeat (250) step();
    chk("mid_rst no_rsp", 32'(rsp_cnt[0] - c0), 32'd0);
    chk("mid_rst rsp_data", 32'(rsp_data[0]), 32'd0);
    run_txn(0, 8'h34, 16'h0102, 0, 24'h0, "d0_after_rst");

    // Minimum-timing instance.
    run_txn(1, 8'h12, 16'hA55A, 0, 24'h0, "d1_echo");
    run_txn(1, 8'hA0, 16'h0005, 1, 24'hFFFFFF, "d1_miso1");
    run_txn(1, 8'h7E, 16'hFFFE, 1, 24'h000000, "d1_miso0");

    for (int n = 0; n < 10; n++) begin
      run_txn(n % 2, 8'($urandom), 16'($urandom), int'($urandom_range(0, 1)),
              24'($urandom), "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
